serial_mult_driver: RTL

SERIAL_MULT_DRIVER -- requirements
Module: serial_mult_driver

---
 rtl/serial_mult_driver_pkg.sv | 22 ++
 rtl/mult_link_shreg.sv | 26 ++
 rtl/serial_mult_driver.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/serial_mult_driver_pkg.sv
// Shared parameters and FSM encoding for the serial multiplier driver.
package serial_mult_driver_pkg;

  localparam int unsigned XW_DEF      = 11;
  localparam int unsigned YW_DEF      = 12;
  localparam int unsigned ZW_DEF      = 23;
  localparam int unsigned TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WAIT_F,
    MUL,
    RECV,
    DONE
  } state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mult_link_shreg.sv
// Shift register with parallel load, serial MSB-in and LSB-out.
// PW selects how many low-order bits are exposed; q[0] is always the serial output.
module mult_link_shreg #(
  parameter int unsigned W  = 8,
  parameter int unsigned PW = W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [W-1:0]  load_data,
  input  logic          shift,
  input  logic          serial_in,
  output logic [PW-1:0] q
);

  logic [W-1:0] r;

  always_ff @(posedge clk) begin
    if (rst)        r <= '0;
    else if (load)  r <= load_data;
    else if (shift) r <= {serial_in, r[W-1:1]};
  end

  assign q = r[PW-1:0];

endmodule

// File: rtl/serial_mult_driver.sv
// Drives a bit-serial multiplier: serializes x/y, handshakes, and captures
// the serial product into z_out.
module serial_mult_driver
  import serial_mult_driver_pkg::*;
#(
  parameter int unsigned XW      = XW_DEF,
  parameter int unsigned YW      = YW_DEF,
  parameter int unsigned ZW      = ZW_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XW-1:0] x_in,
  input  logic [YW-1:0] y_in,
  output logic          x,
  output logic          sx,
  output logic          y,
  output logic          sy,
  input  logic          fx,
  input  logic          fy,
  output logic          mul,
  input  logic          z_serial,
  input  logic          fz,
  output logic [ZW-1:0] z_out,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned MAXW = max_u(XW, YW);
  localparam int unsigned CW   = $clog2(max_u(max_u(MAXW, ZW), TIMEOUT) + 1);

  localparam logic [CW-1:0] XW_C    = CW'(XW);
  localparam logic [CW-1:0] YW_C    = CW'(YW);
  localparam logic [CW-1:0] SH_LAST = CW'(MAXW - 1);
  localparam logic [CW-1:0] Z_LAST  = CW'(ZW - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            load;
  logic            z_shift;
  logic [ZW-1:0]   z_q;
  logic [ZW-1:0]   z_next;

  logic            sx_d, sy_d, mul_d, busy_d, done_d, err_d;
  logic [ZW-1:0]   z_out_d;

  assign load    = (state == IDLE) && start;
  assign z_shift = fz && ((state == MUL) || (state == RECV));
  assign z_next  = {z_serial, z_q[ZW-1:1]};

  // Operand registers shift out zeros, so their LSB is already 0 outside the valid window.
  mult_link_shreg #(.W(XW), .PW(1)) u_x_shreg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (x_in),
    .shift     (state == SHIFT),
    .serial_in (1'b0),
    .q         (x)
  );

  mult_link_shreg #(.W(YW), .PW(1)) u_y_shreg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (y_in),
    .shift     (state == SHIFT),
    .serial_in (1'b0),
    .q         (y)
  );

  mult_link_shreg #(.W(ZW), .PW(ZW)) u_z_shreg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data ('0),
    .shift     (z_shift),
    .serial_in (z_serial),
    .q         (z_q)
  );

  // State and shared bit/timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SHIFT;
          cnt_n   = '0;
        end
      end
      SHIFT: begin
        if (cnt == SH_LAST) begin
          state_n = WAIT_F;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      WAIT_F: begin
        if (fx && fy) begin
          state_n = MUL;
          cnt_n   = '0;
        end else if (cnt == TO_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      MUL: begin
        // First fz-high cycle carries product bit 0.
        if (fz) begin
          state_n = RECV;
          cnt_n   = ONE;
        end else if (cnt == TO_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      RECV: begin
        if (!fz) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == Z_LAST) begin
          state_n = DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      DONE: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Next-cycle output values, derived from the upcoming state.
  always_comb begin
    sx_d    = (state_n == SHIFT) && (cnt_n < XW_C);
    sy_d    = (state_n == SHIFT) && (cnt_n < YW_C);
    mul_d   = (state_n == MUL);
    busy_d  = (state_n != IDLE);
    done_d  = (state_n == DONE);
    err_d   = ((state == WAIT_F) || (state == MUL) || (state == RECV)) && (state_n == IDLE);
    z_out_d = z_out;
    if (state_n == DONE) z_out_d = z_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sx    <= 1'b0;
      sy    <= 1'b0;
      mul   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      z_out <= '0;
    end else begin
      sx    <= sx_d;
      sy    <= sy_d;
      mul   <= mul_d;
      busy  <= busy_d;
      done  <= done_d;
      err   <= err_d;
      z_out <= z_out_d;
    end
  end

endmodule
